uart_tx_param: RTL and testbench

Parametrised successor to the fixed 8N1 UART transmitter. It serialises DATA_BITS-wide words with optional even or odd parity and 1 or 2 stop bits. A small internal FIFO allows the producer to queue several words, which are sent as back-to-back frames with no idle gap. The whole block runs in the ICLK_50 domain; ICLKEN is a synchronous one-cycle baud tick, not a clock.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_param_if.sv | 24 ++
 rtl/uart_fifo.sv | 56 +++++
 rtl/uart_tx_param.sv | 149 ++++++++++++++
 tb/tb_uart_tx_param.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and TX state encoding shared by the UART blocks.
// Parity modes and the 3-bit FSM encoding are reused by the receiver.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // d is zero-extended, so bits at or above n never flip the result
   function automatic logic parity_bit(input logic [8:0] d,
                                       input int n,
                                       input int mode);
      logic p;
      p = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i < n) p = p ^ d[i];
      end
      return (mode == PARITY_ODD) ? ~p : p;
   endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: push/pop and status bundle around the TX word FIFO.
// master produces and consumes words, slave is the FIFO itself.
interface uart_tx_param_if #(
   parameter int W  = 8,
   parameter int LW = 3
);
   logic [W-1:0]  data;
   logic          push;
   logic          pop;
   logic [W-1:0]  rd_data;
   logic          full;
   logic          empty;
   logic [LW-1:0] level;

   modport master (
      output data, push, pop,
      input  rd_data, full, empty, level
   );

   modport slave (
      input  data, push, pop,
      output rd_data, full, empty, level
   );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with registered full/empty flags.
// A push is refused while full even if a pop happens on the same edge.
module uart_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input logic            clk_i,
   input logic            rst_ni,
   uart_tx_param_if.slave f
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [LW-1:0] cnt_q, cnt_d;
   logic          full_q, empty_q;
   logic          wr_en, rd_en;

   assign wr_en = f.push & ~full_q;
   assign rd_en = f.pop & ~empty_q;

   always_comb begin
      cnt_d = cnt_q;
      unique case ({wr_en, rd_en})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (wr_en) wr_q <= wr_q + 1'b1;
         if (rd_en) rd_q <= rd_q + 1'b1;
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == LW'(DEPTH));
         empty_q <= (cnt_d == '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_q] <= f.data;
   end

   assign f.rd_data = mem_q[rd_q];
   assign f.full    = full_q;
   assign f.empty   = empty_q;
   assign f.level   = cnt_q;
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter fed by a word FIFO.
// Frames go out LSB first; queued words follow with no idle gap.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int DEPTH     = 4
) (
   input  logic                       ICLK_50,
   input  logic                       IRST_N,
   input  logic                       ICLKEN,
   input  logic [DATA_BITS-1:0]       IDATA,
   input  logic                       IEN,
   output logic                       OTX,
   output logic                       OTX_BUSY,
   output logic                       OFULL,
   output logic                       OEMPTY,
   output logic [$clog2(DEPTH+1)-1:0] OLEVEL,
   output logic                       OOVF
);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
   localparam logic STOP_LAST = 1'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       (STOP_BITS != 1 && STOP_BITS != 2) || DEPTH < 2 ||
       (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
      $error("uart_tx_param: illegal parameter set");
   end

   uart_tx_param_if #(.W(DATA_BITS), .LW(LW)) fif ();

   tx_state_e            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic                 tx_q, tx_d;
   logic                 par_q, par_d;
   logic                 ovf_q;
   logic                 pop;
   logic                 head_par;

   assign fif.data = IDATA;
   assign fif.push = IEN;
   assign fif.pop  = pop;

   uart_fifo #(.W(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
      .clk_i  (ICLK_50),
      .rst_ni (IRST_N),
      .f      (fif)
   );

   assign head_par = parity_bit(9'(fif.rd_data), DATA_BITS, PARITY);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      tx_d    = tx_q;
      par_d   = par_q;
      pop     = 1'b0;
      if (ICLKEN) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!fif.empty) begin
                  pop     = 1'b1;
                  shift_d = fif.rd_data;
                  par_d   = head_par;
                  tx_d    = 1'b0;
                  state_d = ST_START;
               end
            end
            ST_START: begin
               tx_d    = shift_q[0];
               bit_d   = '0;
               state_d = ST_DATA;
            end
            ST_DATA: begin
               if (bit_q < LAST) begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + 1'b1;
               end else if (PARITY != PARITY_NONE) begin
                  tx_d    = par_q;
                  state_d = ST_PARITY;
               end else begin
                  tx_d    = 1'b1;
                  stop_d  = 1'b0;
                  state_d = ST_STOP;
               end
            end
            ST_PARITY: begin
               tx_d    = 1'b1;
               stop_d  = 1'b0;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               if (stop_q != STOP_LAST) begin
                  stop_d = 1'b1;
               end else if (!fif.empty) begin
                  // next word starts right after the last stop bit
                  pop     = 1'b1;
                  shift_d = fif.rd_data;
                  par_d   = head_par;
                  tx_d    = 1'b0;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               tx_d    = 1'b1;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge ICLK_50 or negedge IRST_N) begin
      if (!IRST_N) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         tx_q    <= 1'b1;
         par_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         tx_q    <= tx_d;
         par_q   <= par_d;
         ovf_q   <= IEN & fif.full;
      end
   end

   assign OTX      = tx_q;
   assign OTX_BUSY = (state_q != ST_IDLE);
   assign OFULL    = fif.full;
   assign OEMPTY   = fif.empty;
   assign OLEVEL   = fif.level;
   assign OOVF     = ovf_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed bench for 8N1, 8E1, 8O1 and 7N2 variants.
// Baud tick is one clock in four; outputs are sampled on falling edges.
module tb_uart_tx_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] cnt = 2'd0;
   logic       tick;
   int         checks = 0;
   int         passes = 0;

   always #10 clk = ~clk;
   always @(posedge clk) cnt <= cnt + 2'd1;
   assign tick = (cnt == 2'd3);

   uart_tx_param_if #(.W(8), .LW(3)) bn ();
   assign bn.pop     = 1'b0;
   assign bn.rd_data = '0;

   logic tx_n, busy_n, ovf_n;

   uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) u_n (
      .ICLK_50 (clk),     .IRST_N   (rst_n),    .ICLKEN (tick),
      .IDATA   (bn.data), .IEN      (bn.push),  .OTX    (tx_n),
      .OTX_BUSY(busy_n),  .OFULL    (bn.full),  .OEMPTY (bn.empty),
      .OLEVEL  (bn.level),.OOVF     (ovf_n)
   );

   logic [7:0] din;
   logic       ien_eo, ien_7;
   logic       tx_e, busy_e, full_e, empty_e, ovf_e;
   logic       tx_o, busy_o, full_o, empty_o, ovf_o;
   logic       tx_7, busy_7, full_7, empty_7, ovf_7;
   logic [2:0] lvl_e, lvl_o, lvl_7;

   uart_tx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DEPTH(4)) u_e (
      .ICLK_50 (clk),    .IRST_N (rst_n),  .ICLKEN (tick),
      .IDATA   (din),    .IEN    (ien_eo), .OTX    (tx_e),
      .OTX_BUSY(busy_e), .OFULL  (full_e), .OEMPTY (empty_e),
      .OLEVEL  (lvl_e),  .OOVF   (ovf_e)
   );

   uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH(4)) u_o (
      .ICLK_50 (clk),    .IRST_N (rst_n),  .ICLKEN (tick),
      .IDATA   (din),    .IEN    (ien_eo), .OTX    (tx_o),
      .OTX_BUSY(busy_o), .OFULL  (full_o), .OEMPTY (empty_o),
      .OLEVEL  (lvl_o),  .OOVF   (ovf_o)
   );

   uart_tx_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .DEPTH(4)) u_7 (
      .ICLK_50 (clk),    .IRST_N (rst_n),    .ICLKEN (tick),
      .IDATA   (din[6:0]), .IEN  (ien_7),    .OTX    (tx_7),
      .OTX_BUSY(busy_7), .OFULL  (full_7),   .OEMPTY (empty_7),
      .OLEVEL  (lvl_7),  .OOVF   (ovf_7)
   );

   // park on the falling edge just before a tick edge
   task automatic wait_tick();
      int n;
      n = 0;
      while (!tick && n < 16) begin
         @(negedge clk);
         n++;
      end
      if (!tick) begin
         checks++;
         $display("FAIL tick_timeout: no baud tick within 16 clocks");
      end
   endtask

   task automatic next_tick();
      wait_tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (tx_n !== 1'b1 || busy_n !== 1'b0 || ovf_n !== 1'b0)
         $display("FAIL reset_line: tx=%b busy=%b ovf=%b want 1 0 0",
                  tx_n, busy_n, ovf_n);
      else passes++;
      checks++;
      if (bn.full !== 1'b0 || bn.empty !== 1'b1 || bn.level !== 3'd0)
         $display("FAIL reset_fifo: full=%b empty=%b lvl=%0d want 0 1 0",
                  bn.full, bn.empty, bn.level);
      else passes++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_8n1();
      logic [9:0] f;
      f = {1'b1, 8'hA5, 1'b0};
      wait_tick();
      bn.data = 8'hA5;
      bn.push = 1'b1;
      @(negedge clk);
      bn.push = 1'b0;
      for (int k = 0; k < 10; k++) begin
         next_tick();
         checks++;
         if (tx_n !== f[k] || busy_n !== 1'b1)
            $display("FAIL 8n1_bit%0d: tx=%b busy=%b want tx=%b busy=1",
                     k, tx_n, busy_n, f[k]);
         else passes++;
      end
      next_tick();
      checks++;
      if (tx_n !== 1'b1 || busy_n !== 1'b0)
         $display("FAIL 8n1_idle: tx=%b busy=%b want 1 0", tx_n, busy_n);
      else passes++;
   endtask

   task automatic test_parity();
      logic [10:0] fe, fo;
      fe = {1'b1, 1'b1, 8'h07, 1'b0};
      fo = {1'b1, 1'b0, 8'h07, 1'b0};
      wait_tick();
      din    = 8'h07;
      ien_eo = 1'b1;
      @(negedge clk);
      ien_eo = 1'b0;
      for (int k = 0; k < 11; k++) begin
         next_tick();
         checks++;
         if (tx_e !== fe[k] || busy_e !== 1'b1)
            $display("FAIL 8e1_bit%0d: tx=%b busy=%b want tx=%b busy=1",
                     k, tx_e, busy_e, fe[k]);
         else passes++;
         checks++;
         if (tx_o !== fo[k] || busy_o !== 1'b1)
            $display("FAIL 8o1_bit%0d: tx=%b busy=%b want tx=%b busy=1",
                     k, tx_o, busy_o, fo[k]);
         else passes++;
      end
      next_tick();
      checks++;
      if (tx_e !== 1'b1 || busy_e !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b0)
         $display("FAIL parity_idle: e tx=%b busy=%b o tx=%b busy=%b want 1 0",
                  tx_e, busy_e, tx_o, busy_o);
      else passes++;
   endtask

   task automatic test_7n2();
      logic [9:0] f;
      f = {2'b11, 7'h55, 1'b0};
      wait_tick();
      din   = 8'h55;
      ien_7 = 1'b1;
      @(negedge clk);
      ien_7 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         next_tick();
         checks++;
         if (tx_7 !== f[k] || busy_7 !== 1'b1)
            $display("FAIL 7n2_bit%0d: tx=%b busy=%b want tx=%b busy=1",
                     k, tx_7, busy_7, f[k]);
         else passes++;
      end
      repeat (2) begin
         next_tick();
         checks++;
         if (tx_7 !== 1'b1 || busy_7 !== 1'b0)
            $display("FAIL 7n2_idle: tx=%b busy=%b want 1 0", tx_7, busy_7);
         else passes++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w [4];
      logic [9:0] fr;
      w = '{8'h11, 8'h22, 8'h33, 8'h44};
      wait_tick();
      for (int i = 0; i < 5; i++) begin
         bn.data = (i < 4) ? w[i] : 8'h99;
         bn.push = 1'b1;
         @(negedge clk);
         if (i == 2) begin
            checks++;
            if (bn.full !== 1'b0 || bn.level !== 3'd3)
               $display("FAIL b2b_push3: full=%b lvl=%0d want 0 3",
                        bn.full, bn.level);
            else passes++;
         end
         if (i == 3) begin
            checks++;
            if (bn.full !== 1'b1 || bn.level !== 3'd4 || ovf_n !== 1'b0)
               $display("FAIL b2b_push4: full=%b lvl=%0d ovf=%b want 1 4 0",
                        bn.full, bn.level, ovf_n);
            else passes++;
         end
      end
      bn.push = 1'b0;
      checks++;
      if (ovf_n !== 1'b1 || bn.level !== 3'd3 || tx_n !== 1'b0)
         $display("FAIL b2b_push5: ovf=%b lvl=%0d tx=%b want 1 3 0",
                  ovf_n, bn.level, tx_n);
      else passes++;
      @(negedge clk);
      checks++;
      if (ovf_n !== 1'b0)
         $display("FAIL b2b_ovf_pulse: ovf=%b want 0", ovf_n);
      else passes++;
      for (int j = 1; j < 40; j++) begin
         next_tick();
         fr = {1'b1, w[j / 10], 1'b0};
         checks++;
         if (tx_n !== fr[j % 10] || busy_n !== 1'b1)
            $display("FAIL b2b_bit%0d: tx=%b busy=%b want tx=%b busy=1",
                     j, tx_n, busy_n, fr[j % 10]);
         else passes++;
         if (j % 10 == 0) begin
            checks++;
            if (bn.level !== 3'(3 - j / 10))
               $display("FAIL b2b_level%0d: lvl=%0d want %0d",
                        j / 10, bn.level, 3 - j / 10);
            else passes++;
         end
      end
      next_tick();
      checks++;
      if (tx_n !== 1'b1 || busy_n !== 1'b0 || bn.empty !== 1'b1)
         $display("FAIL b2b_idle: tx=%b busy=%b empty=%b want 1 0 1",
                  tx_n, busy_n, bn.empty);
      else passes++;
   endtask

   task automatic test_push_pop();
      logic [7:0] w [3];
      logic [9:0] fr;
      w = '{8'h5A, 8'hC3, 8'h0F};
      wait_tick();
      bn.data = w[0];
      bn.push = 1'b1;
      @(negedge clk);
      bn.data = w[1];
      @(negedge clk);
      bn.push = 1'b0;
      checks++;
      if (bn.level !== 3'd2)
         $display("FAIL pp_pre: lvl=%0d want 2", bn.level);
      else passes++;
      repeat (2) @(negedge clk);
      bn.data = w[2];
      bn.push = 1'b1;
      @(negedge clk);
      bn.push = 1'b0;
      checks++;
      if (bn.level !== 3'd2 || tx_n !== 1'b0 || bn.full !== 1'b0)
         $display("FAIL pp_same_cycle: lvl=%0d tx=%b full=%b want 2 0 0",
                  bn.level, tx_n, bn.full);
      else passes++;
      for (int j = 1; j < 30; j++) begin
         next_tick();
         fr = {1'b1, w[j / 10], 1'b0};
         checks++;
         if (tx_n !== fr[j % 10])
            $display("FAIL pp_bit%0d: tx=%b want %b", j, tx_n, fr[j % 10]);
         else passes++;
      end
      next_tick();
      checks++;
      if (tx_n !== 1'b1 || busy_n !== 1'b0 || bn.level !== 3'd0)
         $display("FAIL pp_idle: tx=%b busy=%b lvl=%0d want 1 0 0",
                  tx_n, busy_n, bn.level);
      else passes++;
   endtask

   task automatic test_reset_mid();
      logic [9:0] f;
      f = {1'b1, 8'h3C, 1'b0};
      wait_tick();
      bn.data = 8'h00;
      bn.push = 1'b1;
      @(negedge clk);
      bn.data = 8'hFF;
      @(negedge clk);
      bn.push = 1'b0;
      repeat (3) next_tick();
      checks++;
      if (tx_n !== 1'b0 || busy_n !== 1'b1 || bn.level !== 3'd1)
         $display("FAIL rmid_pre: tx=%b busy=%b lvl=%0d want 0 1 1",
                  tx_n, busy_n, bn.level);
      else passes++;
      #2 rst_n = 1'b0;
      #2;
      checks++;
      if (tx_n !== 1'b1 || busy_n !== 1'b0 || bn.level !== 3'd0 ||
          bn.empty !== 1'b1)
         $display("FAIL rmid_async: tx=%b busy=%b lvl=%0d empty=%b want 1 0 0 1",
                  tx_n, busy_n, bn.level, bn.empty);
      else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      wait_tick();
      bn.data = 8'h3C;
      bn.push = 1'b1;
      @(negedge clk);
      bn.push = 1'b0;
      for (int k = 0; k < 10; k++) begin
         next_tick();
         checks++;
         if (tx_n !== f[k] || busy_n !== 1'b1)
            $display("FAIL rmid_bit%0d: tx=%b busy=%b want tx=%b busy=1",
                     k, tx_n, busy_n, f[k]);
         else passes++;
      end
      next_tick();
      checks++;
      if (tx_n !== 1'b1 || busy_n !== 1'b0 || bn.empty !== 1'b1)
         $display("FAIL rmid_idle: tx=%b busy=%b empty=%b want 1 0 1",
                  tx_n, busy_n, bn.empty);
      else passes++;
   endtask

   initial begin
      rst_n   = 1'b0;
      bn.data = 8'h00;
      bn.push = 1'b0;
      din     = 8'h00;
      ien_eo  = 1'b0;
      ien_7   = 1'b0;
      test_reset();
      test_8n1();
      test_parity();
      test_7n2();
      test_back_to_back();
      test_push_pop();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far",
               passes, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
